rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources:
//  req0 = ALU writeback, req1 = memory-load writeback.
//  Each source uses a valid/ready handshake. A round-robin arbiter grants one source per cycle.
//  The granted write is registered and drives the register file's write enable, address and data one cycle later.
//  Also reports which register is in flight, so the read side can forward it.
// PARAMETERS
//  DATA_W  16  width of write data
//  ADDR_W  4   register address width (2**ADDR_W registers)
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst         in   1       synchronous, active-high reset
//  req0_valid  in   1       ALU source has a write pending
//  req0_reg    in   ADDR_W  ALU destination register
//  req0_data   in   DATA_W  ALU write value
//  req0_ready  out  1       ALU write accepted this cycle
//  req1_valid  in   1       load source has a write pending
//  req1_reg    in   ADDR_W  load destination register
//  req1_data   in   DATA_W  load write value
//  req1_ready  out  1       load write accepted this cycle
//  rf_we       out  1       register file WriteReg
//  rf_wreg     out  ADDR_W  register file DstReg
//  rf_wdata    out  DATA_W  register file DstData
//  inflight    out  1       equals rf_we; rf_wreg/rf_wdata are valid for forwarding
//  conflicts   out  8       saturating count of cycles where both sources were valid
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - rf_we=0, rf_wreg=0, rf_wdata=0, conflicts=0.
//   - Round-robin pointer rr=0, so req0 has priority first.
//   - rst overrides every other input in that cycle; a write accepted in the same cycle is lost.
//  Acceptance (combinational; reqN_ready never depends on reqN_valid):
//   - Only req0 valid -> req0_ready=1.
//   - Only req1 valid -> req1_ready=1.
//   - Both valid -> ready goes to the source named by rr; the other source's ready=0.
//   - Neither valid -> both ready=1. This is harmless because no transfer occurs.
//   - During rst: both ready=0.
//  Transfer and rr update:
//   - A transfer occurs when valid && ready.
//   - At most one transfer per cycle.
//   - rr flips only on a cycle where both sources were valid: it then points to the loser.
//  Output stage, 1-cycle latency:
//   - At the edge after a transfer: rf_we=1, rf_wreg=reg, rf_wdata=data.
//   - With no transfer: rf_we=0; rf_wreg/rf_wdata hold their last values.
//  Register 0:
//   - A transfer to reg 0 is accepted (ready=1) but produces rf_we=0 at the next edge.
//   - It still updates rr and conflicts.
//  Ordering:
//   - Writes to the same register from both sources land in grant order.
//   - Keeping program order across sources is the pipeline's responsibility.
//  conflicts: +1 on each cycle with both valid (and no rst); saturates at 8'hFF.
//  No internal buffering: a source holds valid/reg/data stable until it sees ready.
//  Starvation bound: a continuously valid source waits at most 1 cycle.
// TESTING
//  T1 reset: hold rst 2 cycles with both valid -> ready=00, rf_we=0, conflicts=0.
//  T2 single: req0 valid, reg=3, data=16'hABCD -> req0_ready=1; next cycle rf_we=1, rf_wreg=3, rf_wdata=ABCD.
//  T3 contention: both valid 4 cycles (r0: reg 1, r1: reg 2)
//     -> grants r0,r1,r0,r1; rf_wreg 1,2,1,2 lagging 1 cycle; conflicts=4.
//  T4 reg0 drop: req1 valid, reg=0 -> req1_ready=1; next cycle rf_we=0.
//  T5 saturation: both valid 300 cycles -> conflicts stops at 255.
//  T6 mid-op reset: assert rst in the cycle after a grant
//     -> next edge rf_we=0 and rr=0 (req0 wins the next contention).
//  Random: 1000 cycles of random valid/reg/data.
//     Scoreboard: each accepted nonzero write appears once, in order, one cycle later.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Two writeback request channels (ALU, load) plus the register-file write port they share.
// The master side drives requests; the slave side arbitrates and drives the register-file write.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_wreg;
  logic [DATA_W-1:0] rf_wdata;
  logic              inflight;
  logic [7:0]        conflicts;

  modport master (
    output req0_valid, req0_reg, req0_data,
    input  req0_ready,
    output req1_valid, req1_reg, req1_data,
    input  req1_ready,
    input  rf_we, rf_wreg, rf_wdata, inflight, conflicts
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    output req0_ready,
    input  req1_valid, req1_reg, req1_data,
    output req1_ready,
    output rf_we, rf_wreg, rf_wdata, inflight, conflicts
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin share of the register-file write port between ALU and load writeback; 1-cycle latency.
// Backpressure: a losing source sees ready=0 and must hold valid/reg/data; nothing is buffered here.
module rf_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  rf_write_arbiter_if.slave  bus
);
  logic              rr;
  logic              both_vld;
  logic              rdy0;
  logic              rdy1;
  logic              xfer0;
  logic              xfer1;
  logic              we_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        conflicts_q;

  assign both_vld = bus.req0_valid & bus.req1_valid;

  // Each ready looks only at the other source's valid, so a source never sees its own valid loop back.
  assign rdy0  = !rst && (!bus.req1_valid || !rr);
  assign rdy1  = !rst && (!bus.req0_valid ||  rr);
  assign xfer0 = bus.req0_valid & rdy0;
  assign xfer1 = bus.req1_valid & rdy1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr          <= 1'b0;
      we_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      conflicts_q <= '0;
    end else begin
      we_q <= 1'b0;
      // Register 0 is hardwired: the write is consumed but never reaches the file.
      if (xfer0) begin
        if (bus.req0_reg != '0) begin
          we_q    <= 1'b1;
          wreg_q  <= bus.req0_reg;
          wdata_q <= bus.req0_data;
        end
      end else if (xfer1) begin
        if (bus.req1_reg != '0) begin
          we_q    <= 1'b1;
          wreg_q  <= bus.req1_reg;
          wdata_q <= bus.req1_data;
        end
      end

      if (both_vld) begin
        rr <= ~rr;
        if (conflicts_q != 8'hFF) begin
          conflicts_q <= conflicts_q + 8'd1;
        end
      end
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rf_we      = we_q;
  assign bus.rf_wreg    = wreg_q;
  assign bus.rf_wdata   = wdata_q;
  assign bus.inflight   = we_q;
  assign bus.conflicts  = conflicts_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed vector table plus saturation, mid-op reset and randomized scoreboard runs.
// Inputs change 1ns after each rising edge; readies are sampled before the edge, registered outputs after it.
module tb_rf_write_arbiter;
  logic clk;
  logic rst;

  rf_write_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  rf_write_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        v0;
    logic [3:0]  g0;
    logic [15:0] d0;
    logic        v1;
    logic [3:0]  g1;
    logic [15:0] d1;
    logic        r0;
    logic        r1;
    logic        we;
    logic        chk_dat;
    logic [3:0]  wreg;
    logic [15:0] wdata;
    logic [7:0]  conf;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic drive(input logic r, input logic v0, input logic [3:0] g0, input logic [15:0] d0,
                       input logic v1, input logic [3:0] g1, input logic [15:0] d1);
    rst            = r;
    bus.req0_valid = v0;
    bus.req0_reg   = g0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_reg   = g1;
    bus.req1_data  = d1;
  endtask

  logic [3:0]  q_reg [$];
  logic [15:0] q_dat [$];

  initial begin
    //                 rst  v0   g0    d0        v1   g1    d1        r0   r1   we   chk  wreg  wdata     conf
    vecs[0]  = '{1'b1, 1'b1, 4'd5, 16'h1111, 1'b1, 4'd6, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 4'd5, 16'h1111, 1'b1, 4'd6, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 4'd3, 16'hABCD, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 16'hABCD, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 16'hABCD, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 4'd1, 16'h1001, 1'b1, 4'd2, 16'h2002, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h1001, 8'd1};
    vecs[5]  = '{1'b0, 1'b1, 4'd1, 16'h1001, 1'b1, 4'd2, 16'h2002, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 16'h2002, 8'd2};
    vecs[6]  = '{1'b0, 1'b1, 4'd1, 16'h1001, 1'b1, 4'd2, 16'h2002, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h1001, 8'd3};
    vecs[7]  = '{1'b0, 1'b1, 4'd1, 16'h1001, 1'b1, 4'd2, 16'h2002, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 16'h2002, 8'd4};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 8'd4};
    vecs[9]  = '{1'b0, 1'b1, 4'd0, 16'h0BAD, 1'b1, 4'd7, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 8'd5};
    vecs[10] = '{1'b0, 1'b1, 4'd4, 16'h4444, 1'b1, 4'd7, 16'h7777, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 16'h7777, 8'd6};
    vecs[11] = '{1'b0, 1'b1, 4'd8, 16'h8888, 1'b1, 4'd9, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 16'h8888, 8'd7};
    vecs[12] = '{1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 8'd0};
    vecs[13] = '{1'b0, 1'b1, 4'd10, 16'hAAAA, 1'b1, 4'd9, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b1, 4'd10, 16'hAAAA, 8'd1};

    drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].g0, vecs[i].d0, vecs[i].v1, vecs[i].g1, vecs[i].d1);
      #1;
      chk($sformatf("vec%0d_ready0", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
      chk($sformatf("vec%0d_ready1", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rf_we", i), 32'(bus.rf_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_inflight", i), 32'(bus.inflight), 32'(vecs[i].we));
      chk($sformatf("vec%0d_conflicts", i), 32'(bus.conflicts), 32'(vecs[i].conf));
      if (vecs[i].chk_dat) begin
        chk($sformatf("vec%0d_rf_wreg", i), 32'(bus.rf_wreg), 32'(vecs[i].wreg));
        chk($sformatf("vec%0d_rf_wdata", i), 32'(bus.rf_wdata), 32'(vecs[i].wdata));
      end
    end

    // Saturation: rr=1 and conflicts=1 coming out of the table, so req1 wins on even cycles.
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 4'd1, 16'(i), 1'b1, 4'd2, ~16'(i));
      #1;
      chk("sat_ready0", 32'(bus.req0_ready), 32'(i % 2 == 1));
      chk("sat_ready1", 32'(bus.req1_ready), 32'(i % 2 == 0));
      @(posedge clk);
      #1;
      chk("sat_rf_wreg", 32'(bus.rf_wreg), (i % 2 == 0) ? 32'd2 : 32'd1);
      chk("sat_conflicts", 32'(bus.conflicts), (i + 2 > 255) ? 32'd255 : 32'(i + 2));
    end

    // Randomized traffic against an independent scoreboard.
    drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    begin
      logic       m_rr;
      logic [7:0] m_conf;
      logic       e0, e1, acc0, acc1;
      m_rr   = 1'b0;
      m_conf = 8'd0;
      for (int c = 0; c < 1000; c++) begin
        #1;
        e0 = !bus.req1_valid || !m_rr;
        e1 = !bus.req0_valid ||  m_rr;
        chk("rnd_ready0", 32'(bus.req0_ready), 32'(e0));
        chk("rnd_ready1", 32'(bus.req1_ready), 32'(e1));
        acc0 = bus.req0_valid && e0;
        acc1 = bus.req1_valid && e1;
        if (acc0 && bus.req0_reg != 4'd0) begin
          q_reg.push_back(bus.req0_reg);
          q_dat.push_back(bus.req0_data);
        end else if (acc1 && bus.req1_reg != 4'd0) begin
          q_reg.push_back(bus.req1_reg);
          q_dat.push_back(bus.req1_data);
        end
        if (bus.req0_valid && bus.req1_valid) begin
          m_rr = ~m_rr;
          if (m_conf != 8'hFF) m_conf = m_conf + 8'd1;
        end
        @(posedge clk);
        #1;
        if (q_reg.size() > 0) begin
          chk("rnd_rf_we", 32'(bus.rf_we), 32'd1);
          chk("rnd_rf_wreg", 32'(bus.rf_wreg), 32'(q_reg.pop_front()));
          chk("rnd_rf_wdata", 32'(bus.rf_wdata), 32'(q_dat.pop_front()));
        end else begin
          chk("rnd_rf_we_idle", 32'(bus.rf_we), 32'd0);
        end
        chk("rnd_conflicts", 32'(bus.conflicts), 32'(m_conf));
        if (!bus.req0_valid || acc0) begin
          bus.req0_valid = ($urandom_range(0, 3) != 0);
          bus.req0_reg   = 4'($urandom_range(0, 15));
          bus.req0_data  = 16'($urandom);
        end
        if (!bus.req1_valid || acc1) begin
          bus.req1_valid = ($urandom_range(0, 3) != 0);
          bus.req1_reg   = 4'($urandom_range(0, 15));
          bus.req1_data  = 16'($urandom);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
